// File: rtl/seven_seg_counter_mux.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seven_seg_counter_mux
//
// Four-digit BCD event counter driving a multiplexed, common-anode
// seven-segment display.
//
// The count advances once on each enabled tick and can be cleared
// synchronously. A refresh prescaler steps a 2-bit scan index. The anode and
// cathode outputs are registered from that index and from the digit it
// selects.
//
// Parameters
//   REFRESH_DIV : in_clk cycles each digit is driven (2 .. 2**20)
//
// Ports
//   in_clk   : clock, all state changes on the rising edge
//   reset_n  : asynchronous active-low reset
//   tick     : one-cycle count-advance strobe (advances once per cycle high)
//   enable   : qualifies tick; tick is ignored when low
//   clear    : synchronous zeroing of the count, overrides tick/enable
//   an[3:0]  : active-low anodes, an[0] = ones digit, an[3] = thousands digit
//   seg[6:0] : active-low cathodes ordered {g,f,e,d,c,b,a}
//   rollover : one-cycle pulse following the 9999 -> 0000 wrap
//
// Configuration
//   LEADING_ZERO_BLANK_EN : when defined, a leading zero in digits 1-3 is
//                           blanked. The ones digit is always shown.
// -----------------------------------------------------------------------------
module seven_seg_counter_mux #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       in_clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       enable,
  input  logic       clear,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       rollover
);

  localparam int              PW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_BLANK  = 7'b1111111;
  localparam logic [6:0]      SEG_ZERO   = 7'b1000000;

  // Active-low cathode pattern for one BCD digit. Codes 10-15 cannot occur,
  // but they decode to dark as a safe default.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [3:0][3:0] r_count;     // r_count[0] = ones ... r_count[3] = thousands
  logic [PW-1:0]   r_presc;
  logic [1:0]      r_idx;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_rollover;

  // ---------------------------------------------------------------------------
  // BCD increment
  // ---------------------------------------------------------------------------
  // w_carry_in[i] is high when every digit below i is 9. Digit i therefore
  // receives the carry. w_carry_in[4] marks the 9999 wrap.
  logic [4:0]      w_carry_in;
  logic [3:0][3:0] w_count_inc;
  logic            w_advance;

  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    w_carry_in    = '0;
    w_carry_in[0] = 1'b1;
    w_count_inc   = r_count;
    for (int i = 0; i < 4; i++) begin
      w_carry_in[i+1] = w_carry_in[i] & (r_count[i] == 4'd9);
      if (w_carry_in[i]) begin
        w_count_inc[i] = (r_count[i] == 4'd9) ? 4'd0 : r_count[i] + 4'd1;
      end
    end
  end

  assign w_advance = tick & enable & ~clear;

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // share one asynchronous reset branch, so reset_n low forces them at once,
  // with no clock edge needed.
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_rollover <= 1'b0;
    end else begin
      // clear wins over tick. It never raises rollover, even at 9999.
      if (clear) begin
        r_count <= '0;
      end else if (tick && enable) begin
        r_count <= w_count_inc;
      end
      r_rollover <= w_advance & w_carry_in[4];
    end
  end

  // ---------------------------------------------------------------------------
  // Refresh prescaler and scan index
  // ---------------------------------------------------------------------------
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= '0;
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Display selection
  // ---------------------------------------------------------------------------
  logic [3:0] w_sel_digit;
  logic       w_blank;
  logic [3:0] w_an_next;
  logic [6:0] w_seg_next;

  assign w_sel_digit = r_count[r_idx];

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    w_blank = 1'b0;
    case (r_idx)
      2'd1:    w_blank = (r_count[3:1] == '0);
      2'd2:    w_blank = (r_count[3:2] == '0);
      2'd3:    w_blank = (r_count[3]   == '0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  assign w_an_next  = ~(4'b0001 << r_idx);
  assign w_seg_next = w_blank ? SEG_BLANK : seg_decode(w_sel_digit);

  // The outputs are registered, so they lag count and index changes by one
  // cycle. Because an is decoded from a 2-bit index, exactly one anode is
  // always low.
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_an  <= 4'b1110;
      r_seg <= SEG_ZERO;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
    end
  end

  assign an       = r_an;
  assign seg      = r_seg;
  assign rollover = r_rollover;

endmodule

// File: tb/tb_seven_seg_counter_mux.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_seven_seg_counter_mux
//
// Self-checking bench for seven_seg_counter_mux with REFRESH_DIV = 4.
//
// Each driven cycle pushes the expected {an, seg, rollover} onto a queue. The
// expectation is built from a decimal model of the count, the prescaler and
// the scan index. The entry is popped and compared one time unit after the
// clock edge. Directed checks on top cover reset, scan timing, count value,
// wrap, priority and blanking.
// -----------------------------------------------------------------------------
module tb_seven_seg_counter_mux;

  localparam int DIV = 4;

  logic       in_clk   = 1'b0;
  logic       reset_n  = 1'b0;
  logic       tick     = 1'b0;
  logic       enable   = 1'b0;
  logic       clear    = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       rollover;

  seven_seg_counter_mux #(.REFRESH_DIV(DIV)) dut (
    .in_clk   (in_clk),
    .reset_n  (reset_n),
    .tick     (tick),
    .enable   (enable),
    .clear    (clear),
    .an       (an),
    .seg      (seg),
    .rollover (rollover)
  );

  always #5 in_clk = ~in_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       roll;
  } exp_t;

  exp_t sb[$];

  int m_count = 0;
  int m_presc = 0;
  int m_idx   = 0;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [6:0] model_seg(input int cnt, input int idx);
    int place;
    place = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && cnt < place) return 7'b1111111;
`endif
    return SEG_TAB[(cnt / place) % 10];
  endfunction

  // Drive inputs now, predict the outputs of the coming edge, then compare.
  task automatic step_body(input logic t, input logic e, input logic c);
    exp_t x;
    exp_t got;
    tick   = t;
    enable = e;
    clear  = c;
    x.an   = ~(4'b0001 << m_idx);
    x.seg  = model_seg(m_count, m_idx);
    x.roll = !c && t && e && (m_count == 9999);
    sb.push_back(x);
    if (c)           m_count = 0;
    else if (t && e) m_count = (m_count + 1) % 10000;
    if (m_presc == DIV - 1) begin
      m_presc = 0;
      m_idx   = (m_idx + 1) % 4;
    end else begin
      m_presc++;
    end
    @(posedge in_clk);
    #1;
    got = sb.pop_front();
    check("an",      32'(an),              32'(got.an));
    check("seg",     32'(seg),             32'(got.seg));
    check("roll",    32'(rollover),        32'(got.roll));
    check("one_low", $countones(~an),      32'd1);
  endtask

  task automatic step(input logic t, input logic e, input logic c);
    @(negedge in_clk);
    step_body(t, e, c);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0);
  endtask

  // Assert reset mid-cycle and check the outputs asynchronously. Then release
  // reset and apply a tick on the first edge after release.
  task automatic do_reset();
    @(negedge in_clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_an",   32'(an),       32'h0000000E);
    check("rst_async_seg",  32'(seg),      32'h00000040);
    check("rst_async_roll", 32'(rollover), 32'd0);
    repeat (2) @(posedge in_clk);
    #1;
    check("rst_hold_an",  32'(an),  32'h0000000E);
    check("rst_hold_seg", 32'(seg), 32'h00000040);
    m_count = 0;
    m_presc = 0;
    m_idx   = 0;
    sb.delete();
    @(negedge in_clk);
    reset_n = 1'b1;
    step_body(1'b1, 1'b1, 1'b0);
  endtask

  // Idle until the given anode pattern shows, bounded to two scan periods.
  task automatic seg_at(input logic [3:0] an_want, output logic [6:0] seg_seen);
    bit found;
    found    = 1'b0;
    seg_seen = 7'h00;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (an == an_want) begin
        found    = 1'b1;
        seg_seen = seg;
      end
    end
    check("scan_found", 32'(found), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] s;
    int         held;

    // Reset, then count the cycles spent on the first digit after release.
    do_reset();
    held = (an == 4'b1110) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (an != 4'b1110) break;
      held++;
    end
    check("first_digit_cycles", 32'(held), 32'd4);

    // Free-running scan with the count at 0000.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0);

    // 19 single-cycle ticks give 0019.
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 19; i++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end
    seg_at(4'b1110, s);  check("cnt19_d0", 32'(s), 32'h10);
    seg_at(4'b1101, s);  check("cnt19_d1", 32'(s), 32'h79);

    // clear has priority over tick. A disabled tick is ignored.
    step(1'b0, 1'b1, 1'b1);
    ticks(42);
    seg_at(4'b1110, s);  check("cnt42_d0", 32'(s), 32'h24);
    step(1'b1, 1'b1, 1'b1);
    seg_at(4'b1110, s);  check("clr_prio_d0", 32'(s), 32'h40);
    ticks(3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    seg_at(4'b1110, s);  check("en_off_d0", 32'(s), 32'h30);

    // Wrap 9999 -> 0000 with a single-cycle rollover pulse.
    step(1'b0, 1'b1, 1'b1);
    ticks(9999);
    step(1'b1, 1'b1, 1'b0);
    check("wrap_roll_hi", 32'(rollover), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    check("wrap_roll_lo", 32'(rollover), 32'd0);

    // clear at 9999 does not raise rollover.
    ticks(9999);
    step(1'b0, 1'b1, 1'b1);
    check("clr9999_roll", 32'(rollover), 32'd0);

    // A reset during the rollover pulse kills the pulse at once.
    ticks(9999);
    step(1'b1, 1'b1, 1'b0);
    check("pre_rst_roll", 32'(rollover), 32'd1);
    do_reset();

    // Leading-zero behaviour at 0007.
    step(1'b0, 1'b1, 1'b1);
    ticks(7);
    seg_at(4'b1110, s);  check("blank_d0", 32'(s), 32'h78);
`ifdef LEADING_ZERO_BLANK_EN
    seg_at(4'b1101, s);  check("blank_d1", 32'(s), 32'h7F);
    seg_at(4'b1011, s);  check("blank_d2", 32'(s), 32'h7F);
    seg_at(4'b0111, s);  check("blank_d3", 32'(s), 32'h7F);
`else
    seg_at(4'b1101, s);  check("zero_d1", 32'(s), 32'h40);
    seg_at(4'b1011, s);  check("zero_d2", 32'(s), 32'h40);
    seg_at(4'b0111, s);  check("zero_d3", 32'(s), 32'h40);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_counter_mux.md
SEVEN_SEG_COUNTER_MUX -- requirements
Module: seven_seg_counter_mux

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, the number of in_clk cycles each digit is driven (legal range 2 to 2^20).
REQ-002 The block SHALL have port in_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port tick, input, 1 bit: one-cycle count-advance strobe, driven by the upstream clock divider output.
REQ-005 The block SHALL have port enable, input, 1 bit: when 0, tick is ignored.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous zeroing of the BCD count.
REQ-007 The block SHALL have port an, output, 4 bits: active-low digit anodes; an[0] is the ones digit, an[3] the thousands digit.
REQ-008 The block SHALL have port seg, output, 7 bits: active-low cathodes, ordered {g,f,e,d,c,b,a}.
REQ-009 The block SHALL have port rollover, output, 1 bit: one-cycle pulse on the 9999 -> 0000 wrap.

Function
REQ-010 The block SHALL hold a 4-digit BCD count d3 d2 d1 d0, each digit 0-9.
REQ-011 When clear=1 on an edge, the count SHALL become 0000 on that edge, regardless of tick or enable.
REQ-012 When clear=0, tick=1 and enable=1, the count SHALL increment by one decimal unit on that edge, with BCD carry (x9 -> (x+1)0); the count is visible one cycle after the tick.
REQ-013 The count SHALL remain unchanged when tick=0 or enable=0, and multi-cycle tick SHALL advance once per cycle high.
REQ-014 An increment from 9999 SHALL produce 0000 and assert rollover for exactly the following cycle; clear at 9999 SHALL NOT assert rollover.
REQ-015 A refresh prescaler SHALL count 0 to REFRESH_DIV-1 and wrap; on its wrap, the 2-bit scan index SHALL advance 0->1->2->3->0.
REQ-016 an and seg SHALL be registered: on every edge, an SHALL take the one-cold code of the scan index (index 0 -> 4'b1110, 1 -> 4'b1101, 2 -> 4'b1011, 3 -> 4'b0111), and seg SHALL take the pattern of the digit selected by the scan index, giving one cycle of latency from count or index change.
REQ-017 Segment patterns SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any unreachable code SHALL give 1111111.
REQ-018 Exactly one an bit SHALL be low in every cycle after reset.

Reset
REQ-019 While reset_n=0, the block SHALL asynchronously force: count 0000, prescaler 0, scan index 0, an=4'b1110, seg=7'b1000000, rollover=0.
REQ-020 Release of reset_n SHALL take effect on the first in_clk edge after deassertion; a tick coincident with that edge SHALL be counted.
REQ-021 Reset asserted mid-scan or mid-increment SHALL abandon the operation, with no partial count or rollover pulse.

Configuration
REQ-022 With macro LEADING_ZERO_BLANK_EN defined, seg SHALL be 7'b1111111 for any digit of index 1-3 whose value and all higher digits are zero; an scanning is unchanged, and the ones digit is never blanked.
REQ-023 Without LEADING_ZERO_BLANK_EN, all four digits SHALL always display their value, including leading zeros.

Verification (REFRESH_DIV=4 unless noted)
REQ-024 Reset: hold reset_n=0 mid-run -> immediately an=1110, seg=1000000, rollover=0; after release, the first digit change occurs after 4 cycles.
REQ-025 Scan: free-run 16 cycles with count 0000 -> an sequence 1110,1101,1011,0111, each held for 4 cycles, with exactly one bit low at all times.
REQ-026 Count: 19 single-cycle ticks with enable=1 -> count 0019, and seg while an=1110 is 0010000 (digit 9).
REQ-027 Wrap: preload by ticks to 9999, then one tick -> 0000 and a single-cycle rollover=1; clear at 9999 -> 0000 with rollover=0.
REQ-028 Priority: tick=1, clear=1 at count 0042 -> 0000; tick=1, enable=0 -> count unchanged.
REQ-029 Blanking: with LEADING_ZERO_BLANK_EN at count 0007 -> seg=1111111 for indices 3, 2 and 1, and 1111000 for index 0; without the macro, indices 3-1 show 1000000.
